// File: rtl/drv_rx_monitor.sv
// Receive-side checker for the LED driver serial bus: deserialises every lane, decodes LAT width into a command.
// Latency: SCLK edge to shift update 1 cycle; sampled LAT fall to cmd_valid 2 cycles.
// No backpressure: a pure observer. Command counters are built only with DRV_RX_STATS_EN.
module drv_rx_monitor #(
    parameter int LANES  = 30,
    parameter int WORD_W = 48
) (
    input  logic              clk_enable,
    input  logic              nrst,
    input  logic              driver_sclk,
    input  logic              driver_lat,
    input  logic [LANES-1:0]  drivers_sin,
    input  logic [4:0]        lane_sel,
    input  logic              clr_err,
    output logic              cmd_valid,
    output logic [3:0]        cmd_code,
    output logic [WORD_W-1:0] word_out,
    output logic              lanes_equal,
    output logic [7:0]        bit_count,
    output logic              len_err
`ifdef DRV_RX_STATS_EN
    ,
    output logic [15:0]       wrtgs_cnt,
    output logic [15:0]       latgs_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LATCH, REPORT} state_t;

    state_t            state;
    logic              sclk_q;
    logic              lat_q;
    logic              armed;
    logic [3:0]        lat_w;
    logic [7:0]        bit_cnt;
    logic [WORD_W-1:0] sr [LANES];

    logic              sclk_edge;
    logic              lat_fall;
    logic [3:0]        dec_code;
    logic              len_checked;
    logic              all_eq;
    logic [WORD_W-1:0] sel_word;

    assign sclk_edge   = !sclk_q && driver_sclk;
    assign lat_fall    = lat_q && !driver_lat;
    assign len_checked = (dec_code == 4'd1) || (dec_code == 4'd3) || (dec_code == 4'd5);

    always_comb begin
        dec_code = 4'd0;
        case (lat_w)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13, 4'd15: dec_code = lat_w;
            default: dec_code = 4'd0;
        endcase
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < LANES; i++) begin
            if (sr[i] != sr[0]) all_eq = 1'b0;
        end
    end

    always_comb begin
        sel_word = sr[0];
        if (int'(lane_sel) < LANES) sel_word = sr[lane_sel];
    end

    // Words are framed only by LAT, so the shifters are never cleared by a command.
    always_ff @(posedge clk_enable or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < LANES; i++) sr[i] <= '0;
        end else if (sclk_edge) begin
            for (int i = 0; i < LANES; i++) sr[i] <= {sr[i][WORD_W-2:0], drivers_sin[i]};
        end
    end

    always_ff @(posedge clk_enable or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            sclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            armed       <= 1'b0;
            lat_w       <= 4'd0;
            bit_cnt     <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 4'd0;
            word_out    <= '0;
            lanes_equal <= 1'b0;
            bit_count   <= 8'd0;
            len_err     <= 1'b0;
`ifdef DRV_RX_STATS_EN
            wrtgs_cnt   <= 16'd0;
            latgs_cnt   <= 16'd0;
`endif
        end else begin
            sclk_q    <= driver_sclk;
            lat_q     <= driver_lat;
            cmd_valid <= 1'b0;
            // A LAT already high at reset release is never reported; arm on first low.
            if (!driver_lat) armed <= 1'b1;
            if (clr_err) len_err <= 1'b0;
`ifdef DRV_RX_STATS_EN
            if (clr_err) begin
                wrtgs_cnt <= 16'd0;
                latgs_cnt <= 16'd0;
            end
`endif
            if (sclk_edge) begin
                if (bit_cnt != 8'd255) bit_cnt <= bit_cnt + 8'd1;
                if (driver_lat && lat_w != 4'd15) lat_w <= lat_w + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (driver_lat) state <= LATCH;
                end
                LATCH: begin
                    if (lat_fall) begin
                        if (armed) begin
                            state <= REPORT;
                        end else begin
                            state   <= IDLE;
                            lat_w   <= 4'd0;
                            bit_cnt <= 8'd0;
                        end
                    end
                end
                REPORT: begin
                    cmd_valid   <= 1'b1;
                    cmd_code    <= dec_code;
                    word_out    <= sel_word;
                    lanes_equal <= all_eq;
                    bit_count   <= bit_cnt;
                    if (len_checked && bit_cnt != 8'(WORD_W)) len_err <= 1'b1;
`ifdef DRV_RX_STATS_EN
                    if (dec_code == 4'd1) wrtgs_cnt <= clr_err ? 16'd1 : wrtgs_cnt + 16'd1;
                    if (dec_code == 4'd3) latgs_cnt <= clr_err ? 16'd1 : latgs_cnt + 16'd1;
`endif
                    // An edge landing in this cycle starts the next frame.
                    lat_w   <= (sclk_edge && driver_lat) ? 4'd1 : 4'd0;
                    bit_cnt <= sclk_edge ? 8'd1 : 8'd0;
                    state   <= driver_lat ? LATCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drv_rx_monitor.sv
// Directed bench for drv_rx_monitor; stats checks are compiled in only with DRV_RX_STATS_EN.
module tb_drv_rx_monitor;

    localparam int LANES  = 30;
    localparam int WORD_W = 48;

    logic              clk_enable = 1'b0;
    logic              nrst;
    logic              driver_sclk;
    logic              driver_lat;
    logic [LANES-1:0]  drivers_sin;
    logic [4:0]        lane_sel;
    logic              clr_err;
    logic              cmd_valid;
    logic [3:0]        cmd_code;
    logic [WORD_W-1:0] word_out;
    logic              lanes_equal;
    logic [7:0]        bit_count;
    logic              len_err;
`ifdef DRV_RX_STATS_EN
    logic [15:0]       wrtgs_cnt;
    logic [15:0]       latgs_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n_valid  = 0;

    drv_rx_monitor #(.LANES(LANES), .WORD_W(WORD_W)) dut (
        .clk_enable  (clk_enable),
        .nrst        (nrst),
        .driver_sclk (driver_sclk),
        .driver_lat  (driver_lat),
        .drivers_sin (drivers_sin),
        .lane_sel    (lane_sel),
        .clr_err     (clr_err),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .word_out    (word_out),
        .lanes_equal (lanes_equal),
        .bit_count   (bit_count),
        .len_err     (len_err)
`ifdef DRV_RX_STATS_EN
        ,
        .wrtgs_cnt   (wrtgs_cnt),
        .latgs_cnt   (latgs_cnt)
`endif
    );

    always #5 clk_enable = ~clk_enable;

    always @(negedge clk_enable) begin
        if (cmd_valid) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit = SCLK low phase then high phase; LAT covers the last latw edges.
    // With fall_edge set, LAT drops in the same cycle as the final SCLK rise.
    task automatic send_frame(input logic [47:0] w, input int nbits, input int latw,
                              input logic [LANES-1:0] mask, input int flip, input bit fall_edge);
        logic             b;
        logic             la;
        logic             lb;
        logic [LANES-1:0] v;
        int               idx;
        for (int i = 0; i < nbits; i++) begin
            idx = nbits - 1 - i;
            b   = (idx < 48) ? w[idx[5:0]] : 1'b0;
            v   = b ? mask : '0;
            if (i == nbits - 1 && flip >= 0) v[flip] = ~v[flip];
            if (fall_edge) begin
                la = (i >= nbits - 1 - latw);
                lb = la && (i != nbits - 1);
            end else begin
                la = (i >= nbits - latw);
                lb = la;
            end
            drivers_sin = v;
            driver_sclk = 1'b0;
            driver_lat  = la;
            @(negedge clk_enable);
            driver_sclk = 1'b1;
            driver_lat  = lb;
            @(negedge clk_enable);
        end
        driver_sclk = 1'b0;
        driver_lat  = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_enable);
            if (cmd_valid) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk_enable);
        clr_err = 1'b0;
        @(negedge clk_enable);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [47:0] w2;
        logic [47:0] w4;
        logic [47:0] exp4;
        int          n0;

        nrst        = 1'b0;
        driver_sclk = 1'b0;
        driver_lat  = 1'b0;
        drivers_sin = '0;
        lane_sel    = 5'd0;
        clr_err     = 1'b0;
        repeat (2) @(negedge clk_enable);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_code",  64'(cmd_code),  64'd0);
        check("rst_word",  64'(word_out),  64'd0);
        check("rst_eq",    64'(lanes_equal), 64'd0);
        check("rst_bits",  64'(bit_count), 64'd0);
        check("rst_err",   64'(len_err),   64'd0);
        nrst = 1'b1;
        @(negedge clk_enable);

        // WRTGS on lane 0 only, with exact latency and single-cycle pulse
        send_frame(48'hA5A5_0F0F_1234, 48, 1, 30'd1, -1, 1'b0);
        @(negedge clk_enable);
        check("t1_valid_n1", 64'(cmd_valid), 64'd0);
        @(negedge clk_enable);
        check("t1_valid_n2", 64'(cmd_valid), 64'd1);
        check("t1_code", 64'(cmd_code),  64'd1);
        check("t1_word", 64'(word_out),  64'hA5A5_0F0F_1234);
        check("t1_bits", 64'(bit_count), 64'd48);
        check("t1_err",  64'(len_err),   64'd0);
        check("t1_eq",   64'(lanes_equal), 64'd0);
        @(negedge clk_enable);
        check("t1_valid_n3", 64'(cmd_valid), 64'd0);
        check("t1_code_hold", 64'(cmd_code), 64'd1);

        // LATGS on all lanes, then with lane 17 bit 0 flipped
        w2       = 48'h1357_9BDF_2468;
        lane_sel = 5'd17;
        send_frame(w2, 48, 3, '1, -1, 1'b0);
        wait_cmd("t2_valid");
        check("t2_code", 64'(cmd_code),    64'd3);
        check("t2_eq",   64'(lanes_equal), 64'd1);
        check("t2_word", 64'(word_out),    64'(w2));
        send_frame(w2, 48, 3, '1, 17, 1'b0);
        wait_cmd("t3_valid");
        check("t3_code", 64'(cmd_code),    64'd3);
        check("t3_eq",   64'(lanes_equal), 64'd0);
        check("t3_word", 64'(word_out),    64'(w2 ^ 48'h1));

        // Short WRTFC: 47 edges; out-of-range lane_sel reads lane 0
        w4       = 48'h0F1E_2D3C_4B5A;
        exp4     = {w2[0], w4[46:0]};
        lane_sel = 5'd31;
        send_frame(w4, 47, 5, '1, -1, 1'b0);
        wait_cmd("t4_valid");
        check("t4_code", 64'(cmd_code),  64'd5);
        check("t4_bits", 64'(bit_count), 64'd47);
        check("t4_err",  64'(len_err),   64'd1);
        check("t4_word", 64'(word_out),  64'(exp4));

        // Invalid width 4 leaves the sticky error alone
        lane_sel = 5'd0;
        send_frame(48'h8000_0000_0001, 48, 4, '1, -1, 1'b0);
        wait_cmd("t5_valid");
        check("t5_code", 64'(cmd_code), 64'd0);
        check("t5_err",  64'(len_err),  64'd1);
        check("t5_word", 64'(word_out), 64'h8000_0000_0001);
        pulse_clr();
        check("clr_err", 64'(len_err), 64'd0);
        send_frame(48'h0, 30, 4, '1, -1, 1'b0);
        wait_cmd("t6_valid");
        check("t6_code", 64'(cmd_code),  64'd0);
        check("t6_bits", 64'(bit_count), 64'd30);
        check("t6_err",  64'(len_err),   64'd0);

        // LAT falls in the same cycle as the last SCLK rise
        send_frame(48'hDEAD_BEEF_CAFE, 48, 3, '1, -1, 1'b1);
        wait_cmd("t7_valid");
        check("t7_code", 64'(cmd_code),  64'd3);
        check("t7_bits", 64'(bit_count), 64'd48);
        check("t7_word", 64'(word_out),  64'hDEAD_BEEF_CAFE);
        check("t7_err",  64'(len_err),   64'd0);

        // LAT width saturates at 15; bit count saturates at 255
        send_frame(48'h1, 48, 20, '1, -1, 1'b0);
        wait_cmd("t8_valid");
        check("t8_code", 64'(cmd_code), 64'd15);
        check("t8_err",  64'(len_err),  64'd0);
        send_frame(48'h0, 300, 1, '1, -1, 1'b0);
        wait_cmd("t9_valid");
        check("t9_code", 64'(cmd_code),  64'd1);
        check("t9_bits", 64'(bit_count), 64'd255);
        check("t9_err",  64'(len_err),   64'd1);
        pulse_clr();
        check("t9_clr", 64'(len_err), 64'd0);

`ifdef DRV_RX_STATS_EN
        check("st_wrtgs_clr", 64'(wrtgs_cnt), 64'd0);
        check("st_latgs_clr", 64'(latgs_cnt), 64'd0);
        for (int f = 0; f < 16; f++) begin
            send_frame(48'h5A5A_5A5A_5A5A, 48, 1, '1, -1, 1'b0);
            wait_cmd("st_wrtgs_valid");
        end
        send_frame(48'h5A5A_5A5A_5A5A, 48, 3, '1, -1, 1'b0);
        wait_cmd("st_latgs_valid");
        @(negedge clk_enable);
        check("st_wrtgs", 64'(wrtgs_cnt), 64'd16);
        check("st_latgs", 64'(latgs_cnt), 64'd1);
`endif

        // Reset mid-word discards the partial word and counters
        send_frame(48'hFFFF_FFFF_FFFF, 20, 0, '1, -1, 1'b0);
        nrst = 1'b0;
        @(negedge clk_enable);
        check("mr_code", 64'(cmd_code),  64'd0);
        check("mr_word", 64'(word_out),  64'd0);
        check("mr_bits", 64'(bit_count), 64'd0);
        nrst = 1'b1;
        @(negedge clk_enable);
        n0 = n_valid;
        send_frame(48'h0123_4567_89AB, 48, 1, '1, -1, 1'b0);
        wait_cmd("mr_valid");
        repeat (3) @(negedge clk_enable);
        check("mr_npulse", 64'(n_valid - n0), 64'd1);
        check("mr_bits48", 64'(bit_count), 64'd48);
        check("mr_word48", 64'(word_out),  64'h0123_4567_89AB);

        // LAT already high at reset release is never reported
        driver_lat = 1'b1;
        nrst       = 1'b0;
        repeat (2) @(negedge clk_enable);
        nrst = 1'b1;
        @(negedge clk_enable);
        n0 = n_valid;
        send_frame(48'h7, 3, 3, '1, -1, 1'b0);
        repeat (8) @(negedge clk_enable);
        check("lh_npulse", 64'(n_valid - n0), 64'd0);
        send_frame(48'hFEDC_BA98_7654, 48, 1, '1, -1, 1'b0);
        wait_cmd("lh_valid");
        check("lh_code", 64'(cmd_code),  64'd1);
        check("lh_bits", 64'(bit_count), 64'd48);
        check("lh_err",  64'(len_err),   64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/drv_rx_monitor.md
# drv_rx_monitor

Receive-side model of the LED driver serial interface. It observes `driver_sclk`, `driver_lat` and the 30 `drivers_sin` lanes exactly as the driver controller emits them. Per lane it deserialises 48-bit words and decodes the latch command from the LAT pulse width counted in SCLK rising edges. It reports each completed command with its data, and flags framing errors. It is used in loopback on the board test points and as a synthesizable checker in the driver bring-up design.

## Interface
Parameters:
- `LANES`, 30: number of serial data lanes.
- `WORD_W`, 48: bits per driver shift-register word.

Ports:
- `clk_enable`  in  1  block clock; all inputs are synchronous to it.
- `nrst`  in  1  reset, asynchronous, active-low.
- `driver_sclk`  in  1  driver serial clock, sampled as data.
- `driver_lat`  in  1  driver latch, sampled as data.
- `drivers_sin`  in  LANES  serial data, one bit per lane.
- `lane_sel`  in  5  lane whose word appears on `word_out`; values ≥ LANES select lane 0.
- `cmd_valid`  out  1  one-cycle pulse when a command completes.
- `cmd_code`  out  4  decoded command; holds its value until the next command.
- `word_out`  out  WORD_W  word captured on lane `lane_sel` at the last command.
- `lanes_equal`  out  1  all lanes held identical words at the last command.
- `bit_count`  out  8  SCLK edges since the previous command, saturating at 255.
- `len_err`  out  1  sticky flag; set when a WRTGS, LATGS or WRTFC command completes with `bit_count` ≠ WORD_W.
- `clr_err`  in  1  synchronous clear of `len_err` and of the counters.
- `wrtgs_cnt`, `latgs_cnt`  out  16  command counters; present only with the stats macro.

## Operation
- An edge is detected when `sclk_q`=0 and `driver_sclk`=1, where `sclk_q` is the sampled SCLK registered on `clk_enable`.
- On every edge:
  - each lane shifts `drivers_sin[i]` into the LSB of its WORD_W shift register; MSB is first on the wire.
  - if `driver_lat`=1, `lat_w` increments, saturating at 15.
  - `bit_count` increments, saturating at 255.
- End of command occurs when `lat_q`=1 and `driver_lat`=0. Decoding uses `lat_w`:
  - 1 → WRTGS (code 1)
  - 3 → LATGS (code 3)
  - 5 → WRTFC (code 5)
  - 7 → READFC (code 7)
  - 11 → FCWRTEN (code 11)
  - 13 → LINERESET (code 13)
  - 15 → TMGRST (code 15)
  - any other width → code 0 (INVALID). `len_err` is not set for code 0.
- At end of command the block:
  - registers `cmd_code`, `word_out`, `lanes_equal` and the final `bit_count`;
  - pulses `cmd_valid`;
  - clears `lat_w` and the running bit counter.
- If an SCLK edge occurs in the same cycle as the LAT fall, the edge is counted and shifted before the command is decoded.
- FSM states:
  - IDLE: LAT low. Goes to LATCH when LAT is sampled high.
  - LATCH: counting LAT width. Goes to REPORT when LAT falls.
  - REPORT: one cycle; asserts `cmd_valid`. Goes to LATCH if LAT is high again, otherwise to IDLE.
- The shift registers are never cleared by a command. Words are framed purely by LAT.
- `clr_err` clears `len_err` and the stats counters. If `clr_err` coincides with an error, the error wins and `len_err` stays set.

## Timing
- Reset values: all outputs 0, shift registers 0, state IDLE, `sclk_q` 0, `lat_q` 0.
- SCLK edge to shift-register update: 1 cycle (one register stage after sampling).
- Sampled LAT fall to `cmd_valid` high: 2 cycles. `cmd_code` and `word_out` are valid in the same cycle as `cmd_valid` and remain stable afterwards.
- SCLK must stay high and low for at least 1 `clk_enable` cycle each. Narrower pulses are not detected; no error is flagged for them.
- Reset asserted mid-word discards the partial word. No `cmd_valid` is produced for a LAT that was already high when reset released. Such a LAT is treated as starting in LATCH with `lat_w`=0.

## Configuration
- `DRV_RX_STATS_EN` defined: `wrtgs_cnt` and `latgs_cnt` exist. Each increments on its own command with `cmd_valid` and wraps at 16 bits.
- `DRV_RX_STATS_EN` undefined: both ports are removed and no counter logic is built.

## Test plan
- Lane 0 sends 48 bits of 0xA5A5_0F0F_1234, with LAT high on the last edge only → `cmd_valid` once, `cmd_code`=1, `word_out`=0xA5A5_0F0F_1234, `bit_count`=48, `len_err`=0.
- All lanes send the same word with a LAT width of 3 → `cmd_code`=3, `lanes_equal`=1. Repeat with lane 17 bit 0 flipped → `lanes_equal`=0.
- 47 edges, then a LAT width of 5 → `cmd_code`=5, `bit_count`=47, `len_err`=1. Then pulse `clr_err` → `len_err`=0.
- A LAT width of 4 → `cmd_code`=0, `len_err` unchanged.
- With `DRV_RX_STATS_EN` defined, send 16 WRTGS followed by 1 LATGS → `wrtgs_cnt`=16, `latgs_cnt`=1.
- Assert `nrst` after 20 edges, then send a full 48-bit WRTGS → exactly one `cmd_valid`, with `bit_count`=48.
